// File: rtl/hazard_control_unit.sv
// Pipeline hazard control: memory stalls, branch flushes and load-use bubbles.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_control_unit #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             idex_is_load,
  input  logic [4:0]       idex_rd,
  input  logic [4:0]       ifid_rs1,
  input  logic [4:0]       ifid_rs2,
  input  logic             ifid_uses_rs1,
  input  logic             ifid_uses_rs2,
  input  logic             br_taken,
  input  logic             imem_read,
  input  logic             imem_resp,
  input  logic             dmem_read,
  input  logic             dmem_write,
  input  logic             dmem_resp,
  output logic             pc_ld,
  output logic             ifid_ld,
  output logic             idex_ld,
  output logic             exmem_ld,
  output logic             memwb_ld,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] bubble_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [1:0] RUN       = 2'd0;
  localparam logic [1:0] MEM_STALL = 2'd1;
  localparam logic [1:0] LU_BUBBLE = 2'd2;

  logic [1:0] state, state_nxt;
  logic       pending_flush, pending_nxt;
  logic       mem_wait, load_use, rs1_hit, rs2_hit;

  assign mem_wait = (imem_read & ~imem_resp) | ((dmem_read | dmem_write) & ~dmem_resp);
  assign rs1_hit  = ifid_uses_rs1 & (ifid_rs1 == idex_rd);
  assign rs2_hit  = ifid_uses_rs2 & (ifid_rs2 == idex_rd);
  assign load_use = idex_is_load & (idex_rd != 5'd0) & (rs1_hit | rs2_hit);

  always_comb begin
    pc_ld       = 1'b0;
    ifid_ld     = 1'b0;
    idex_ld     = 1'b0;
    exmem_ld    = 1'b0;
    memwb_ld    = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    state_nxt   = RUN;
    pending_nxt = pending_flush;
    if (rst) begin
      pending_nxt = 1'b0;
    end else if (mem_wait) begin
      // a branch resolved while frozen is remembered and applied once unstalled
      state_nxt   = MEM_STALL;
      pending_nxt = pending_flush | br_taken;
    end else if (br_taken | pending_flush) begin
      {pc_ld, ifid_ld, idex_ld, exmem_ld, memwb_ld} = 5'b11111;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      pending_nxt = 1'b0;
    end else if (load_use && state != LU_BUBBLE) begin
      {pc_ld, ifid_ld, idex_ld, exmem_ld, memwb_ld} = 5'b00111;
      idex_bubble = 1'b1;
      state_nxt   = LU_BUBBLE;
    end else begin
      {pc_ld, ifid_ld, idex_ld, exmem_ld, memwb_ld} = 5'b11111;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= RUN;
      pending_flush <= 1'b0;
    end else begin
      state         <= state_nxt;
      pending_flush <= pending_nxt;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic flush_evt, bubble_evt;
  // load-use bubble is the only bubble raised without a flush
  assign flush_evt  = ifid_flush;
  assign bubble_evt = idex_bubble & ~ifid_flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      bubble_count <= '0;
      flush_count  <= '0;
    end else begin
      if (mem_wait && stall_cycles != '1)   stall_cycles <= stall_cycles + CNT_W'(1);
      if (bubble_evt && bubble_count != '1) bubble_count <= bubble_count + CNT_W'(1);
      if (flush_evt && flush_count != '1)   flush_count  <= flush_count + CNT_W'(1);
    end
  end
`else
  assign stall_cycles = '0;
  assign bubble_count = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: doc/hazard_control_unit.md
HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 Parameter: CNT_W, 32, width of each performance counter.
REQ-002 clk  input  1  single pipeline clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 idex_is_load  input  1  instruction in ID/EX is a load.
REQ-005 idex_rd  input  5  destination register of the ID/EX instruction.
REQ-006 ifid_rs1, ifid_rs2  input  5 each  source registers of the IF/ID instruction.
REQ-007 ifid_uses_rs1, ifid_uses_rs2  input  1 each  IF/ID instruction reads that source.
REQ-008 br_taken  input  1  EX stage resolved a taken branch or jump.
REQ-009 imem_read, imem_resp  input  1 each  instruction-memory request and response.
REQ-010 dmem_read, dmem_write, dmem_resp  input  1 each  data-memory requests and response.
REQ-011 pc_ld, ifid_ld, idex_ld, exmem_ld, memwb_ld  output  1 each  pipeline register load enables.
REQ-012 ifid_flush  output  1  clear IF/ID to a NOP on the next edge.
REQ-013 idex_bubble  output  1  load a NOP into ID/EX on the next edge.
REQ-014 stall_cycles, bubble_count, flush_count  output  CNT_W each  performance counters (REQ-030).

Function
REQ-015 mem_wait = (imem_read & ~imem_resp) | ((dmem_read | dmem_write) & ~dmem_resp).
REQ-016 load_use = idex_is_load & idex_rd != 0 & ((ifid_uses_rs1 & ifid_rs1 == idex_rd) | (ifid_uses_rs2 & ifid_rs2 == idex_rd)).
REQ-017 FSM states: RUN, MEM_STALL, LU_BUBBLE; reset state RUN.
REQ-018 Priority every cycle: mem_wait > flush (br_taken or pending_flush) > load_use.
REQ-019 mem_wait in any state: all five load enables 0, ifid_flush 0, idex_bubble 0; next state MEM_STALL.
REQ-020 MEM_STALL with mem_wait low: outputs per RUN rules this cycle; next state RUN or LU_BUBBLE per REQ-022.
REQ-021 Flush (no mem_wait): all load enables 1, ifid_flush 1, idex_bubble 1 for exactly one cycle; load_use ignored that cycle.
REQ-022 load_use (no mem_wait, no flush) in RUN: pc_ld 0, ifid_ld 0, idex_ld 1, exmem_ld 1, memwb_ld 1, idex_bubble 1; next state LU_BUBBLE.
REQ-023 LU_BUBBLE: load_use not re-asserted for the same held instruction; all enables 1, no bubble; next state RUN.
REQ-024 br_taken while mem_wait: pending_flush register set; flush applied on first cycle with mem_wait low, then pending_flush cleared.
REQ-025 No hazard: all load enables 1, ifid_flush 0, idex_bubble 0.
REQ-026 Outputs combinational from state, pending_flush and inputs; zero-cycle latency.

Reset
REQ-027 rst high: state RUN, pending_flush 0, all counters 0, immediately (asynchronous).
REQ-028 During rst: all load enables 0, ifid_flush 0, idex_bubble 0.
REQ-029 Reset asserted mid-stall or mid-bubble discards pending_flush; first post-reset cycle evaluated from RUN.

Configuration
REQ-030 Macro HAZARD_PERF_CNT_EN defined: stall_cycles +1 per mem_wait cycle, bubble_count +1 per load-use bubble, flush_count +1 per applied flush; each saturates at all-ones.
REQ-031 Macro undefined: counter registers absent; stall_cycles, bubble_count, flush_count tied to 0; REQ-015..029 unchanged.

Verification
REQ-032 ID/EX load x5, IF/ID add using rs1=x5 -> one cycle pc_ld=0, ifid_ld=0, idex_bubble=1; next cycle all enables 1; bubble_count=1.
REQ-033 Load with idex_rd=x0, rs1=x0 -> no bubble, all enables 1.
REQ-034 dmem_read held 3 cycles without dmem_resp -> all enables 0 for 3 cycles; stall_cycles=3; enables 1 on dmem_resp cycle.
REQ-035 br_taken during 2-cycle imem stall -> no flush while stalled; ifid_flush=1, idex_bubble=1 on first unstalled cycle only; flush_count=1.
REQ-036 br_taken and load_use same cycle -> flush only, no pc_ld hold; bubble_count unchanged.
REQ-037 rst pulsed mid-MEM_STALL with pending_flush set -> counters 0, no flush after reset; macro undefined -> counters read 0 throughout.
